vga_scan_ctrl: RTL and testbench

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_scan_ctrl_if.sv | 10 +
 rtl/pix_tick_gen.sv | 32 +++
 rtl/vga_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing defaults, sizes and the scan state type for the VGA scan controller.
package vga_pkg;
  localparam int PIX_DIV_DEF = 2;
  localparam int H_ACT_DEF   = 640;
  localparam int H_FP_DEF    = 16;
  localparam int H_SYN_DEF   = 96;
  localparam int H_BP_DEF    = 48;
  localparam int V_ACT_DEF   = 480;
  localparam int V_FP_DEF    = 10;
  localparam int V_SYN_DEF   = 2;
  localparam int V_BP_DEF    = 33;
  localparam int H_TOT       = H_ACT_DEF + H_FP_DEF + H_SYN_DEF + H_BP_DEF;
  localparam int V_TOT       = V_ACT_DEF + V_FP_DEF + V_SYN_DEF + V_BP_DEF;
  localparam int IMG_W_DEF   = 160;
  localparam int SHIFT_DEF   = 2;

  localparam int ADDR_W  = 15;
  localparam int COLOR_W = 4;
  localparam int RGB_W   = 3 * COLOR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;
endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Image ROM port: texel address out from the scanner, RGB444 texel back.
interface vga_scan_ctrl_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  logic [RGB_W-1:0]  rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/pix_tick_gen.sv
// Free-running pixel strobe: one vga_clk-wide pulse every PIX_DIV cycles (PIX_DIV >= 2),
// first pulse PIX_DIV cycles after reset release.
module pix_tick_gen #(
  parameter int PIX_DIV = 2
) (
  input  logic vga_clk,
  input  logic reset,
  output logic tick
);
  localparam int            CW   = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(PIX_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == '0) ? LOAD : cnt_q - 1'b1;
    tick_d = (cnt_q == CW'(1));
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster scanner: pixel/line counters, frame sequencing, texel fetch from an image ROM
// and sync generation, with sync/RGB aligned one pixel behind the issued ROM address.
//   state | meaning
//   IDLE  | counters parked at 0,0; syncs high, RGB and address 0
//   RUN   | scanning frames back to back
//   DRAIN | enable dropped; finish the current frame, then IDLE
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int PIX_DIV = PIX_DIV_DEF,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYN   = H_SYN_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYN   = V_SYN_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter int IMG_W   = IMG_W_DEF,
  parameter int SHIFT   = SHIFT_DEF
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic                   enable,
  vga_scan_ctrl_if.master        rom,
  output logic                   hsync_n,
  output logic                   vsync_n,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   pix_tick,
  output logic                   frame_start,
  output logic                   busy
);
  localparam int HT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int VT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0]     H_LAST  = HW'(HT - 1);
  localparam logic [HW-1:0]     H_ACT_C = HW'(H_ACT);
  localparam logic [HW-1:0]     HS_BEG  = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0]     HS_END  = HW'(H_ACT + H_FP + H_SYN - 1);
  localparam logic [VW-1:0]     V_LAST  = VW'(VT - 1);
  localparam logic [VW-1:0]     V_ACT_C = VW'(V_ACT);
  localparam logic [VW-1:0]     VS_BEG  = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0]     VS_END  = VW'(V_ACT + V_FP + V_SYN - 1);
  localparam logic [ADDR_W-1:0] IMG_W_C = ADDR_W'(IMG_W);

  scan_state_t       state_q, state_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              act_q, act_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              frame_end;

  pix_tick_gen #(.PIX_DIV(PIX_DIV)) u_tick (
    .vga_clk (vga_clk),
    .reset   (reset),
    .tick    (tick)
  );

  // Dropping enable on the very last tick of a frame goes straight to IDLE rather than
  // draining a whole extra frame.
  always_comb begin
    state_d   = state_q;
    frame_end = (h_q == H_LAST) && (v_q == V_LAST);
    unique case (state_q)
      IDLE:    if (tick && enable) state_d = RUN;
      RUN:     if (!enable) state_d = (tick && frame_end) ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)                 state_d = RUN;
        else if (tick && frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/active flag are built from the next counter values so they hold for the
  // whole pixel; sync and RGB are built from the current pixel and so trail by one.
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;
    act_d  = act_q;
    rgb_d  = rgb_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    fs_d   = 1'b0;
    busy_d = (state_d != IDLE);
    if (tick) begin
      if (state_q != IDLE) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      fs_d   = (state_d == RUN) && (h_d == '0) && (v_d == '0);
      act_d  = (state_d != IDLE) && (h_d < H_ACT_C) && (v_d < V_ACT_C);
      addr_d = act_d ? (IMG_W_C * ADDR_W'(v_d >> SHIFT)) + ADDR_W'(h_d >> SHIFT) : '0;
      rgb_d  = act_q ? rom.rom_data : '0;
      hs_d   = !((state_q != IDLE) && (h_q >= HS_BEG) && (h_q <= HS_END));
      vs_d   = !((state_q != IDLE) && (v_q >= VS_BEG) && (v_q <= VS_END));
    end
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      act_q   <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      act_q   <= act_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end

  assign rom.rom_addr = addr_q;
  assign vga_r        = rgb_q[RGB_W-1 -: COLOR_W];
  assign vga_g        = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_b        = rgb_q[COLOR_W-1:0];
  assign hsync_n      = hs_q;
  assign vsync_n      = vs_q;
  assign pix_tick     = tick;
  assign frame_start  = fs_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench: a full 800x525 instance for line/address timing and a reduced-raster
// instance (88x24 pixels, 16-texel image) for whole-frame sequencing.
`timescale 1ns/1ps
module tb_vga_scan_ctrl;
  localparam int SH_TOT = 88;
  localparam int SV_TOT = 24;
  localparam int FH_TOT = 800;
  localparam int FV_TOT = 525;

  logic vga_clk = 1'b0;
  logic reset_n;
  logic en_f, en_s;

  vga_scan_ctrl_if rom_f();
  vga_scan_ctrl_if rom_s();

  logic       hs_f, vs_f, pt_f, fs_f, busy_f;
  logic [3:0] r_f, g_f, b_f;
  logic       hs_s, vs_s, pt_s, fs_s, busy_s;
  logic [3:0] r_s, g_s, b_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fh = 0, fv = 0, sh = 0, sv = 0;

  always #5 vga_clk = ~vga_clk;
  always @(negedge vga_clk) cyc <= cyc + 1;

  assign rom_f.rom_data = (rom_f.rom_addr == 15'd161) ? 12'hF0A : (rom_f.rom_addr[11:0] ^ 12'hA50);
  assign rom_s.rom_data = rom_s.rom_addr[11:0] ^ 12'hA50;

  vga_scan_ctrl u_full (
    .vga_clk(vga_clk), .reset(reset_n), .enable(en_f), .rom(rom_f),
    .hsync_n(hs_f), .vsync_n(vs_f), .vga_r(r_f), .vga_g(g_f), .vga_b(b_f),
    .pix_tick(pt_f), .frame_start(fs_f), .busy(busy_f)
  );

  vga_scan_ctrl #(
    .PIX_DIV(2), .H_ACT(64), .H_FP(4), .H_SYN(12), .H_BP(8),
    .V_ACT(16), .V_FP(2), .V_SYN(2), .V_BP(4), .IMG_W(16), .SHIFT(2)
  ) u_small (
    .vga_clk(vga_clk), .reset(reset_n), .enable(en_s), .rom(rom_s),
    .hsync_n(hs_s), .vsync_n(vs_s), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .pix_tick(pt_s), .frame_start(fs_s), .busy(busy_s)
  );

  // One pixel = two vga_clk cycles; positions are the bench's own raster model.
  task automatic f_step();
    repeat (2) @(negedge vga_clk);
    if (fh == FH_TOT-1) begin fh = 0; fv = (fv == FV_TOT-1) ? 0 : fv + 1; end
    else fh++;
  endtask

  task automatic f_goto(input int h, input int v);
    int n = 0;
    while (!(fh == h && fv == v) && n < FH_TOT*FV_TOT) begin f_step(); n++; end
  endtask

  task automatic s_step();
    repeat (2) @(negedge vga_clk);
    if (sh == SH_TOT-1) begin sh = 0; sv = (sv == SV_TOT-1) ? 0 : sv + 1; end
    else sh++;
  endtask

  task automatic s_goto(input int h, input int v);
    int n = 0;
    while (!(sh == h && sv == v) && n < SH_TOT*SV_TOT) begin s_step(); n++; end
  endtask

  task automatic s_sync(input int bound, output bit ok);
    int n = 0;
    @(negedge vga_clk);
    while (fs_s !== 1'b1 && n < bound) begin @(negedge vga_clk); n++; end
    ok = (fs_s === 1'b1);
    sh = 0; sv = 0;
  endtask

  task automatic test_reset();
    int bad = 0;
    reset_n = 1'b0; en_f = 1'b0; en_s = 1'b0;
    repeat (3) @(negedge vga_clk);
    checks++;
    if ({rom_s.rom_addr, r_s, g_s, b_s, hs_s, vs_s, pt_s, fs_s, busy_s} !== {15'd0, 12'd0, 5'b11000}) begin
      errors++; $display("FAIL reset_small got %h exp %h",
        {rom_s.rom_addr, r_s, g_s, b_s, hs_s, vs_s, pt_s, fs_s, busy_s}, {15'd0, 12'd0, 5'b11000});
    end
    checks++;
    if ({rom_f.rom_addr, r_f, g_f, b_f, hs_f, vs_f, pt_f, fs_f, busy_f} !== {15'd0, 12'd0, 5'b11000}) begin
      errors++; $display("FAIL reset_full got %h exp %h",
        {rom_f.rom_addr, r_f, g_f, b_f, hs_f, vs_f, pt_f, fs_f, busy_f}, {15'd0, 12'd0, 5'b11000});
    end
    en_f = 1'b1; en_s = 1'b1; reset_n = 1'b1;
    @(negedge vga_clk);
    checks++;
    if ({pt_s, pt_f, busy_s} !== 3'b000) begin
      errors++; $display("FAIL tick_cycle1 got %b exp 000", {pt_s, pt_f, busy_s});
    end
    @(negedge vga_clk);
    checks++;
    if ({pt_s, pt_f, fs_s, busy_s} !== 4'b1100) begin
      errors++; $display("FAIL tick_cycle2 got %b exp 1100", {pt_s, pt_f, fs_s, busy_s});
    end
    @(negedge vga_clk);
    checks++;
    if ({fs_s, fs_f, pt_s, busy_s, busy_f, hs_s} !== 6'b110111 || rom_s.rom_addr !== 15'd0) begin
      errors++; $display("FAIL entry_frame_start got %b addr %0d exp 110111 addr 0",
        {fs_s, fs_f, pt_s, busy_s, busy_f, hs_s}, rom_s.rom_addr);
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge vga_clk);
      if (pt_s !== ((i % 2) == 1) || pt_f !== ((i % 2) == 1) || fs_s !== 1'b0) bad++;
    end
    fh = 10; sh = 10;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tick_period got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_line_end();
    f_goto(639, 0);
    checks++;
    if (rom_f.rom_addr !== 15'd159) begin
      errors++; $display("FAIL addr_639_0 got %0d exp 159", rom_f.rom_addr);
    end
    f_step();
    checks++;
    if (rom_f.rom_addr !== 15'd0) begin
      errors++; $display("FAIL addr_640_0 got %0d exp 0", rom_f.rom_addr);
    end
    checks++;
    if ({r_f, g_f, b_f} !== 12'hACF) begin
      errors++; $display("FAIL rgb_640_0 got %h exp acf", {r_f, g_f, b_f});
    end
    f_step();
    checks++;
    if ({r_f, g_f, b_f} !== 12'h000) begin
      errors++; $display("FAIL rgb_641_0 got %h exp 000", {r_f, g_f, b_f});
    end
  endtask

  task automatic test_hsync();
    int first0 = -1, first1 = -1, low0 = 0, vs_bad = 0;
    while (!(fh == 657 && fv == 1)) begin
      f_step();
      if (vs_f !== 1'b1) vs_bad++;
      if (hs_f === 1'b0) begin
        if (fv == 0) begin low0++; if (first0 < 0) first0 = fh; end
        else if (first1 < 0) first1 = fh;
      end
    end
    checks++;
    if (first0 != 657) begin errors++; $display("FAIL hsync_start got %0d exp 657", first0); end
    checks++;
    if (low0 != 96) begin errors++; $display("FAIL hsync_width got %0d exp 96", low0); end
    checks++;
    if (first1 + FH_TOT - first0 != 800) begin
      errors++; $display("FAIL line_length got %0d exp 800", first1 + FH_TOT - first0);
    end
    checks++;
    if (vs_bad != 0) begin errors++; $display("FAIL vsync_top got %0d low exp 0", vs_bad); end
  endtask

  task automatic test_rom_rgb();
    f_goto(4, 4);
    checks++;
    if (rom_f.rom_addr !== 15'd161) begin
      errors++; $display("FAIL addr_4_4 got %0d exp 161", rom_f.rom_addr);
    end
    checks++;
    if ({r_f, g_f, b_f} !== 12'hAF0) begin
      errors++; $display("FAIL rgb_4_4 got %h exp af0", {r_f, g_f, b_f});
    end
    f_step();
    checks++;
    if ({r_f, g_f, b_f} !== 12'hF0A) begin
      errors++; $display("FAIL rgb_texel_f0a got %h exp f0a", {r_f, g_f, b_f});
    end
  endtask

  task automatic test_frame_period();
    bit ok;
    int c0;
    s_sync(5000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_sync got timeout exp frame_start"); end
    c0 = cyc;
    s_sync(5000, ok);
    checks++;
    if (!ok || cyc - c0 != 2*SH_TOT*SV_TOT) begin
      errors++; $display("FAIL frame_period got %0d exp %0d", cyc - c0, 2*SH_TOT*SV_TOT);
    end
  endtask

  task automatic test_vsync_addr();
    s_goto(63, 15);
    checks++;
    if (rom_s.rom_addr !== 15'd63) begin
      errors++; $display("FAIL addr_last_active got %0d exp 63", rom_s.rom_addr);
    end
    s_step();
    checks++;
    if (rom_s.rom_addr !== 15'd0) begin
      errors++; $display("FAIL addr_hblank got %0d exp 0", rom_s.rom_addr);
    end
    s_goto(0, 18);
    checks++;
    if (vs_s !== 1'b1) begin errors++; $display("FAIL vsync_0_18 got %b exp 1", vs_s); end
    s_step();
    checks++;
    if (vs_s !== 1'b0) begin errors++; $display("FAIL vsync_1_18 got %b exp 0", vs_s); end
    s_goto(0, 20);
    checks++;
    if (vs_s !== 1'b0) begin errors++; $display("FAIL vsync_0_20 got %b exp 0", vs_s); end
    s_step();
    checks++;
    if (vs_s !== 1'b1) begin errors++; $display("FAIL vsync_1_20 got %b exp 1", vs_s); end
  endtask

  task automatic test_drain();
    int bad = 0;
    s_goto(0, 5);
    en_s = 1'b0;
    s_goto(40, 15);
    checks++;
    if (busy_s !== 1'b1 || rom_s.rom_addr !== 15'd58) begin
      errors++; $display("FAIL drain_scan got busy %b addr %0d exp 1 58", busy_s, rom_s.rom_addr);
    end
    s_goto(SH_TOT-1, SV_TOT-1);
    checks++;
    if (busy_s !== 1'b1) begin errors++; $display("FAIL drain_last_pixel got %b exp 1", busy_s); end
    s_step();
    checks++;
    if ({busy_s, hs_s, vs_s, r_s, g_s, b_s} !== {3'b011, 12'h000} || rom_s.rom_addr !== 15'd0) begin
      errors++; $display("FAIL drain_idle got %h addr %0d exp 3000 0",
        {busy_s, hs_s, vs_s, r_s, g_s, b_s}, rom_s.rom_addr);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge vga_clk);
      if (fs_s !== 1'b0 || busy_s !== 1'b0 || hs_s !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_quiet got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_restore();
    bit ok;
    int c0;
    int bad = 0;
    en_s = 1'b1;
    s_sync(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_frame_start got timeout exp pulse"); end
    c0 = cyc;
    s_goto(0, 10);
    en_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_step();
      if (busy_s !== 1'b1) bad++;
    end
    en_s = 1'b1;
    checks++;
    if (bad != 0 || rom_s.rom_addr !== 15'd33) begin
      errors++; $display("FAIL restore_no_gap got %0d bad addr %0d exp 0 33", bad, rom_s.rom_addr);
    end
    s_sync(5000, ok);
    checks++;
    if (!ok || cyc - c0 != 2*SH_TOT*SV_TOT) begin
      errors++; $display("FAIL restore_boundary got %0d exp %0d", cyc - c0, 2*SH_TOT*SV_TOT);
    end
  endtask

  task automatic test_reset_mid();
    s_goto(30, 12);
    checks++;
    if ({r_s, g_s, b_s} !== 12'hA67 || rom_s.rom_addr !== 15'd55) begin
      errors++; $display("FAIL pre_reset_pixel got %h addr %0d exp a67 55", {r_s, g_s, b_s}, rom_s.rom_addr);
    end
    s_goto(75, 12);
    checks++;
    if (hs_s !== 1'b0) begin errors++; $display("FAIL pre_reset_hsync got %b exp 0", hs_s); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rom_s.rom_addr, r_s, g_s, b_s, hs_s, vs_s, pt_s, fs_s, busy_s} !== {15'd0, 12'd0, 5'b11000}) begin
      errors++; $display("FAIL reset_mid got %h exp %h",
        {rom_s.rom_addr, r_s, g_s, b_s, hs_s, vs_s, pt_s, fs_s, busy_s}, {15'd0, 12'd0, 5'b11000});
    end
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (3) @(negedge vga_clk);
    checks++;
    if ({fs_s, busy_s} !== 2'b11 || rom_s.rom_addr !== 15'd0) begin
      errors++; $display("FAIL reset_restart got %b addr %0d exp 11 0", {fs_s, busy_s}, rom_s.rom_addr);
    end
    sh = 0; sv = 0;
    s_goto(4, 1);
    checks++;
    if (rom_s.rom_addr !== 15'd1) begin
      errors++; $display("FAIL restart_addr got %0d exp 1", rom_s.rom_addr);
    end
    s_step();
    checks++;
    if ({r_s, g_s, b_s} !== 12'hA51) begin
      errors++; $display("FAIL restart_rgb got %h exp a51", {r_s, g_s, b_s});
    end
  endtask

  initial begin
    test_reset();
    test_line_end();
    test_hsync();
    test_rom_rgb();
    test_frame_period();
    test_vsync_addr();
    test_drain();
    test_restore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
